// File: rtl/i2s_rx_if.sv
// FIFO write-side bundle for the I2S receiver: stereo sample pair, write strobe
// and the full flag coming back from the FIFO.
interface i2s_rx_if #(
   parameter int unsigned DW = 24
);
   logic [DW-1:0] l_sample;
   logic [DW-1:0] r_sample;
   logic          wr_en;
   logic          wr_full;

   modport master (
      output l_sample,
      output r_sample,
      output wr_en,
      input  wr_full
   );

   modport slave (
      input  l_sample,
      input  r_sample,
      input  wr_en,
      output wr_full
   );
endinterface

// File: rtl/i2s_rx.sv
// I2S slave receiver. Oversamples sclk/lrclk/sdi in the audio clock domain,
// deserializes left/right words and writes one stereo frame per lrclk period.
module i2s_rx #(
   parameter int unsigned DW = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       lrclk,
   input  logic       sdi,
   i2s_rx_if.master   fifo,
   output logic       locked,
   output logic       overflow
);

   localparam int unsigned CW = $clog2(DW + 1);
   localparam logic [CW-1:0] DwC = CW'(DW);

   typedef enum logic [1:0] {StHunt, StLeft, StRight} state_e;

   logic sclk_meta, sclk_sync, sclk_prev;
   logic lrclk_meta, lrclk_sync;
   logic sdi_meta, sdi_sync;

   state_e         state_q, state_d;
   logic           ws_d_q, ws_d_d;
   logic [CW-1:0]  count_q, count_d;
   logic [DW-1:0]  shreg_q, shreg_d;
   logic [DW-1:0]  l_hold_q, l_hold_d;
   logic [DW-1:0]  l_sample_q, r_sample_q;
   logic           wr_en_q, overflow_q;

   logic           rise, ws, sd, word_end, frame_done;
   logic [CW-1:0]  count_acc;
   logic [DW-1:0]  shreg_acc, aligned;

   // Two-flop synchronizers plus the previous-sclk register for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_meta  <= 1'b0;
         sclk_sync  <= 1'b0;
         sclk_prev  <= 1'b0;
         lrclk_meta <= 1'b0;
         lrclk_sync <= 1'b0;
         sdi_meta   <= 1'b0;
         sdi_sync   <= 1'b0;
      end else begin
         sclk_meta  <= sclk;
         sclk_sync  <= sclk_meta;
         sclk_prev  <= sclk_sync;
         lrclk_meta <= lrclk;
         lrclk_sync <= lrclk_meta;
         sdi_meta   <= sdi;
         sdi_sync   <= sdi_meta;
      end
   end

   assign rise     = sclk_sync & ~sclk_prev;
   assign ws       = lrclk_sync;
   assign sd       = sdi_sync;
   assign word_end = rise & (ws != ws_d_q);

   // Next-state: bit accumulation, word alignment and HUNT/LEFT/RIGHT sequencing.
   always_comb begin
      state_d    = state_q;
      ws_d_d     = ws_d_q;
      count_d    = count_q;
      shreg_d    = shreg_q;
      l_hold_d   = l_hold_q;
      frame_done = 1'b0;

      // Bits beyond DW are dropped; the count saturates at DW.
      if (count_q < DwC) begin
         shreg_acc = {shreg_q[DW-2:0], sd};
         count_acc = count_q + CW'(1);
      end else begin
         shreg_acc = shreg_q;
         count_acc = count_q;
      end
      // Left-align short words; a zero-length word shifts out completely.
      aligned = shreg_acc << (DwC - count_acc);

      if (rise) begin
         ws_d_d = ws;
         unique case (state_q)
            StHunt: begin
               count_d = '0;
               shreg_d = '0;
               if (ws_d_q && !ws) state_d = StLeft;
            end
            StLeft: begin
               if (word_end) begin
                  l_hold_d = aligned;
                  count_d  = '0;
                  shreg_d  = '0;
                  state_d  = StRight;
               end else begin
                  count_d = count_acc;
                  shreg_d = shreg_acc;
               end
            end
            StRight: begin
               if (word_end) begin
                  frame_done = 1'b1;
                  count_d    = '0;
                  shreg_d    = '0;
                  state_d    = StLeft;
               end else begin
                  count_d = count_acc;
                  shreg_d = shreg_acc;
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   // Capture state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StHunt;
         ws_d_q   <= 1'b0;
         count_q  <= '0;
         shreg_q  <= '0;
         l_hold_q <= '0;
      end else begin
         state_q  <= state_d;
         ws_d_q   <= ws_d_d;
         count_q  <= count_d;
         shreg_q  <= shreg_d;
         l_hold_q <= l_hold_d;
      end
   end

   // Registered FIFO write; a frame completing while full is dropped and flagged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         l_sample_q <= '0;
         r_sample_q <= '0;
         wr_en_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_en_q <= frame_done & ~fifo.wr_full;
         if (frame_done && !fifo.wr_full) begin
            l_sample_q <= l_hold_q;
            r_sample_q <= aligned;
         end
         if (frame_done && fifo.wr_full) overflow_q <= 1'b1;
      end
   end

   assign fifo.l_sample = l_sample_q;
   assign fifo.r_sample = r_sample_q;
   assign fifo.wr_en    = wr_en_q;
   assign locked        = (state_q != StHunt);
   assign overflow      = overflow_q;

endmodule
